tdp_req_arb: RTL and testbench

- Upstream feeder for one port of the true-dual-port RAM block.
- Merges a write-request stream and a read-address stream into the single combined request stream the RAM port consumes: ctrl bit plus data plus addr.
- Arbitrates round-robin between the two streams, with a bounded burst length.
- Registers the merged request for timing. One instance sits in front of each RAM port.

---
 rtl/tdp_req_arb_if.sv | 11 +
 rtl/tdp_req_arb.sv | 118 +++++++++++
 tb/tb_tdp_req_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdp_req_arb_if.sv
// Valid/ready stream bundle used for the write, read and merged request paths.
interface tdp_req_arb_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/tdp_req_arb.sv
// Merges a write-request stream and a read-address stream into the single
// registered request stream of one RAM port. Round-robin arbitration with a
// bounded burst: a source keeps the grant for up to MAX_BURST consecutive
// transfers while the other source is waiting.
module tdp_req_arb #(
  parameter int W_DATA    = 16,
  parameter int W_ADDR    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdp_req_arb_if.consumer   wr_req,
  tdp_req_arb_if.consumer   rd_req,
  tdp_req_arb_if.producer   req
);

  localparam int          W_REQ     = 1 + W_DATA + W_ADDR;
  localparam logic [7:0]  BURST_LIM = 8'(MAX_BURST);

  typedef enum logic {
    SRC_WR = 1'b0,
    SRC_RD = 1'b1
  } src_e;

  src_e             last_q, last_d, gnt_src;
  logic [7:0]       cnt_q, cnt_d;
  logic             load;
  logic             gnt_wr, gnt_rd, xfer;
  logic [W_REQ-1:0] packed_p0;
  logic [W_REQ-1:0] data_p1;
  logic             vld_p1;

  // Run-length counter saturates so a long single-source run never wraps
  // back below the burst limit.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [W_REQ-1:0] pack_wr(input logic [W_DATA+W_ADDR-1:0] p);
    return {1'b1, p};
  endfunction

  // Reads carry no payload; the data field is forced to zero.
  function automatic logic [W_REQ-1:0] pack_rd(input logic [W_ADDR-1:0] a);
    return {1'b0, {W_DATA{1'b0}}, a};
  endfunction

  // The output slot can take a new request when empty or being drained.
  assign load = !vld_p1 || req.ready;

  // Grant selection: a lone valid source wins; on a tie the last source keeps
  // the grant until its run reaches the burst limit.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (load) begin
      if (wr_req.valid && rd_req.valid) begin
        if ((cnt_q < BURST_LIM) == (last_q == SRC_WR)) gnt_wr = 1'b1;
        else                                           gnt_rd = 1'b1;
      end else begin
        gnt_wr = wr_req.valid;
        gnt_rd = rd_req.valid;
      end
    end
  end

  assign xfer         = gnt_wr || gnt_rd;
  assign wr_req.ready = gnt_wr;
  assign rd_req.ready = gnt_rd;

  // Stage p0: pack the granted request.
  always_comb begin
    packed_p0 = pack_rd(rd_req.data);
    if (gnt_wr) packed_p0 = pack_wr(wr_req.data);
  end

  // Next arbitration state; only an accepted transfer moves it, so a stalled
  // output freezes last/cnt.
  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_src = gnt_wr ? SRC_WR : SRC_RD;
    if (xfer) begin
      if (gnt_src == last_q) begin
        cnt_d = sat_inc(cnt_q);
      end else begin
        last_d = gnt_src;
        cnt_d  = 8'd1;
      end
    end
  end

  // Arbitration state register; WR wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_WR;
      cnt_q  <= 8'd0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  // Stage p1: output register; data holds when the slot empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1 <= xfer;
      if (xfer) data_p1 <= packed_p0;
    end
  end

  assign req.valid = vld_p1;
  assign req.data  = data_p1;

endmodule

// File: tb/tb_tdp_req_arb.sv
// Randomized scoreboard bench for tdp_req_arb with a run-length reference model.
module tb_tdp_req_arb;

  localparam int W_DATA    = 16;
  localparam int W_ADDR    = 16;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;

  tdp_req_arb_if #(.W(W_DATA + W_ADDR))     wr_if ();
  tdp_req_arb_if #(.W(W_ADDR))              rd_if ();
  tdp_req_arb_if #(.W(1 + W_DATA + W_ADDR)) req_if ();

  tdp_req_arb #(
    .W_DATA    (W_DATA),
    .W_ADDR    (W_ADDR),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_req (wr_if),
    .rd_req (rd_if),
    .req    (req_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the source of the current run and its unbounded length.
  logic [32:0] mq[$];
  logic        m_vld     = 1'b0;
  int          run_src   = 0;   // 0 = write, 1 = read
  int          run_len   = 0;
  logic        wr_acc_m  = 1'b0;
  logic        rd_acc_m  = 1'b0;
  logic        rec_en    = 1'b0;
  logic        rec[$];

  always @(negedge clk) begin
    int  g;
    logic ld;
    if (rst) begin
      mq.delete();
      m_vld    = 1'b0;
      run_src  = 0;
      run_len  = 0;
      wr_acc_m = 1'b0;
      rd_acc_m = 1'b0;
    end else begin
      chk("req_valid", req_if.valid, m_vld);
      ld = !m_vld || req_if.ready;
      g  = -1;
      if (ld) begin
        if (wr_if.valid && rd_if.valid) g = (run_len < MAX_BURST) ? run_src : 1 - run_src;
        else if (wr_if.valid)           g = 0;
        else if (rd_if.valid)           g = 1;
      end
      chk("wr_ready", wr_if.ready, g == 0);
      chk("rd_ready", rd_if.ready, g == 1);
      wr_acc_m = (g == 0);
      rd_acc_m = (g == 1);
      if (g == 0) mq.push_back({1'b1, wr_if.data[31:16], wr_if.data[15:0]});
      if (g == 1) mq.push_back({1'b0, 16'h0000, rd_if.data});
      if (g >= 0) begin
        if (g == run_src) run_len++;
        else begin
          run_src = g;
          run_len = 1;
        end
      end
      if (ld) m_vld = (g >= 0);
    end
  end

  // Monitor: every presented output must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && req_if.valid) begin
      if (mq.size() == 0) begin
        chk("req_unexpected", 64'd1, 64'd0);
      end else begin
        chk("req_data", req_if.data, mq[0]);
        if (req_if.ready) begin
          if (rec_en) rec.push_back(req_if.data[32]);
          void'(mq.pop_front());
        end
      end
    end
  end

  // One clock of stimulus: retire accepted inputs, refill with given odds.
  task automatic step(input int pw, input int pr, input int pready);
    @(posedge clk);
    #1;
    if (wr_if.valid && wr_acc_m) wr_if.valid = 1'b0;
    if (rd_if.valid && rd_acc_m) rd_if.valid = 1'b0;
    if (!wr_if.valid && $urandom_range(99) < pw) begin
      wr_if.valid = 1'b1;
      wr_if.data  = $urandom;
    end
    if (!rd_if.valid && $urandom_range(99) < pr) begin
      rd_if.valid = 1'b1;
      rd_if.data  = 16'($urandom);
    end
    req_if.ready = ($urandom_range(99) < pready);
  endtask

  task automatic do_reset();
    wr_if.valid = 1'b0;
    rd_if.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int          got;
    rst          = 1'b1;
    wr_if.valid  = 1'b0;
    wr_if.data   = '0;
    rd_if.valid  = 1'b0;
    rd_if.data   = '0;
    req_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_valid", req_if.valid, 0);
    chk("rst_wr_ready", wr_if.ready, 0);
    chk("rst_rd_ready", rd_if.ready, 0);

    // Single write, then single read with zeroed data field.
    wr_if.valid = 1'b1;
    wr_if.data  = {16'h00AB, 16'h0010};
    step(0, 0, 100);
    chk("wr_single_valid", req_if.valid, 1);
    chk("wr_single_data", req_if.data, {1'b1, 16'h00AB, 16'h0010});
    step(0, 0, 100);
    chk("wr_single_idle", req_if.valid, 0);
    rd_if.valid = 1'b1;
    rd_if.data  = 16'h0020;
    step(0, 0, 100);
    chk("rd_single_data", req_if.data, {1'b0, 16'h0000, 16'h0020});
    step(0, 0, 100);

    // Both streams saturated with a 5-cycle stall in the middle.
    do_reset();
    rec.delete();
    rec_en      = 1'b1;
    wr_if.valid = 1'b1;
    wr_if.data  = $urandom;
    rd_if.valid = 1'b1;
    rd_if.data  = 16'($urandom);
    req_if.ready = 1'b1;
    repeat (6) step(100, 100, 100);
    repeat (5) step(100, 100, 0);
    for (int k = 0; k < 40 && rec.size() < 16; k++) step(100, 100, 100);
    rec_en = 1'b0;
    chk("burst_count", rec.size() >= 16, 1);
    pat = 16'b1111_0000_1111_0000;
    for (int i = 0; i < 16 && i < rec.size(); i++) chk("burst_order", rec[i], pat[15-i]);

    // Long read-only run, then a write must be served promptly.
    do_reset();
    rd_if.valid  = 1'b1;
    rd_if.data   = 16'($urandom);
    req_if.ready = 1'b1;
    repeat (10) step(0, 100, 100);
    wr_if.valid = 1'b1;
    wr_if.data  = $urandom;
    got = -1;
    for (int k = 0; k < MAX_BURST + 2; k++) begin
      @(negedge clk);
      if (wr_if.ready) begin
        got = k;
        break;
      end
      step(100, 100, 100);
    end
    chk("wr_wait_bound", (got >= 0) && (got < MAX_BURST), 1);
    repeat (4) step(0, 0, 100);

    // Reset while an output is stalled; first tie afterwards goes to WR.
    wr_if.valid = 1'b1;
    wr_if.data  = $urandom;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_rst_stalled", req_if.valid, 1);
    do_reset();
    chk("post_rst_valid", req_if.valid, 0);
    wr_if.valid  = 1'b1;
    wr_if.data   = $urandom;
    rd_if.valid  = 1'b1;
    rd_if.data   = 16'($urandom);
    req_if.ready = 1'b1;
    @(negedge clk);
    chk("tie_wr_ready", wr_if.ready, 1);
    chk("tie_rd_ready", rd_if.ready, 0);

    // Random traffic with random backpressure.
    repeat (3000) step(50, 50, 70);
    repeat (10) step(0, 0, 100);
    chk("drain_empty", mq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
